// File: rtl/core_pkg.sv
// Shared core definitions: ALU op codes, forward-select encoding,
// default datapath widths and the ID/EX control bundle.
package core_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0001;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXM,
        FWD_WB
    } fwd_sel_e;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       alu_src_imm;
        logic       use_pc;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_fwd_unit.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB,
// x0 never forwarded.
module id_ex_fwd_unit
    import core_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rs_data,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_data
);

    logic     exm_hit;
    logic     wb_hit;
    fwd_sel_e sel;

    assign exm_hit = exm_reg_write && (exm_rd_addr != '0)
                  && (exm_rd_addr == rs_addr);
    assign wb_hit  = !exm_hit && wb_reg_write
                  && (wb_rd_addr != '0) && (wb_rd_addr == rs_addr);

    always_comb begin
        sel = FWD_REG;
        unique case (1'b1)
            exm_hit: sel = FWD_EXM;
            wb_hit:  sel = FWD_WB;
            default: sel = FWD_REG;
        endcase
    end

    always_comb begin
        fwd_data = rs_data;
        case (sel)
            FWD_EXM: fwd_data = exm_result;
            FWD_WB:  fwd_data = wb_data;
            default: fwd_data = rs_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding into the ALU.
// Optional stall/flush counters enabled by ID_EX_PERF_CNT_EN.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [3:0]        in_alu_ctrl,
    input  logic              in_alu_src_imm,
    input  logic              in_use_pc,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_branch,
    input  logic              flush_i,
    input  logic              out_ready,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    output logic [XLEN-1:0]   operand_a_o,
    output logic [XLEN-1:0]   operand_b_o,
    output logic [3:0]        alu_ctrl_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
`ifdef ID_EX_PERF_CNT_EN
    output logic              branch_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`else
    output logic              branch_o
`endif
);

    logic              valid_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    logic [XLEN-1:0]   imm_q;
    logic [REG_AW-1:0] rs1_addr_q;
    logic [REG_AW-1:0] rs2_addr_q;
    logic [REG_AW-1:0] rd_q;
    id_ex_ctrl_t       ctrl_q;
    id_ex_ctrl_t       ctrl_d;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;
    logic              load;

    assign in_ready = !valid_q || out_ready || flush_i;
    assign load     = in_valid && in_ready && !flush_i;

    assign ctrl_d = '{
        alu_ctrl:    in_alu_ctrl,
        alu_src_imm: in_alu_src_imm,
        use_pc:      in_use_pc,
        reg_write:   in_reg_write,
        mem_read:    in_mem_read,
        mem_write:   in_mem_write,
        branch:      in_branch
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
        end else if (flush_i) begin
            valid_q    <= 1'b0;
        end else if (load) begin
            valid_q    <= 1'b1;
            pc_q       <= in_pc;
            rs1_q      <= in_rs1_data;
            rs2_q      <= in_rs2_data;
            imm_q      <= in_imm;
            rs1_addr_q <= in_rs1_addr;
            rs2_addr_q <= in_rs2_addr;
            rd_q       <= in_rd_addr;
            ctrl_q     <= ctrl_d;
        end else if (valid_q && out_ready) begin
            valid_q    <= 1'b0;
        end else if (valid_q) begin
            // Stalled: absorb producers that retire while we wait.
            rs1_q      <= fwd_rs1;
            rs2_q      <= fwd_rs2;
        end
    end

    id_ex_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_addr       (rs1_addr_q),
        .rs_data       (rs1_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .fwd_data      (fwd_rs1)
    );

    id_ex_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_addr       (rs2_addr_q),
        .rs_data       (rs2_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .fwd_data      (fwd_rs2)
    );

    assign out_valid    = valid_q;
    assign operand_a_o  = ctrl_q.use_pc ? pc_q : fwd_rs1;
    assign operand_b_o  = ctrl_q.alu_src_imm ? imm_q : fwd_rs2;
    assign store_data_o = fwd_rs2;
    assign alu_ctrl_o   = ctrl_q.alu_ctrl;
    assign pc_o         = pc_q;
    assign rd_addr_o    = rd_q;
    assign reg_write_o  = valid_q && ctrl_q.reg_write;
    assign mem_read_o   = valid_q && ctrl_q.mem_read;
    assign mem_write_o  = valid_q && ctrl_q.mem_write;
    assign branch_o     = valid_q && ctrl_q.branch;

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (valid_q && !out_ready)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_i && (valid_q || in_valid))
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_id_ex_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [3:0]  in_alu_ctrl;
    logic        in_alu_src_imm, in_use_pc;
    logic        in_reg_write, in_mem_read, in_mem_write, in_branch;
    logic        flush_i, out_ready;
    logic        exm_reg_write, wb_reg_write;
    logic [4:0]  exm_rd_addr, wb_rd_addr;
    logic [31:0] exm_result, wb_data;
    logic        out_valid;
    logic [31:0] operand_a_o, operand_b_o, store_data_o, pc_o;
    logic [3:0]  alu_ctrl_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o, mem_read_o, mem_write_o, branch_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    int tests = 0;
    int fails = 0;
    int run_len = 0;
    int max_run = 0;

    typedef struct {
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  a1, a2, rd;
        logic [3:0]  op;
        logic        si, up, rw, mr, mw, br;
    } ins_t;

    ins_t q[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data),
        .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rd_addr(in_rd_addr), .in_alu_ctrl(in_alu_ctrl),
        .in_alu_src_imm(in_alu_src_imm), .in_use_pc(in_use_pc),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_branch(in_branch),
        .flush_i(flush_i), .out_ready(out_ready),
        .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr),
        .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
        .wb_data(wb_data),
        .out_valid(out_valid),
        .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
        .alu_ctrl_o(alu_ctrl_o), .store_data_o(store_data_o),
        .pc_o(pc_o), .rd_addr_o(rd_addr_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o),
`ifdef ID_EX_PERF_CNT_EN
        .branch_o(branch_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`else
        .branch_o(branch_o)
`endif
    );

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Newest producer wins; x0 reads always come from the register file.
    function automatic logic [31:0] fwd(logic [4:0] a, logic [31:0] d);
        if (a == 5'd0) return d;
        if (exm_reg_write && exm_rd_addr == a) return exm_result;
        if (wb_reg_write && wb_rd_addr == a) return wb_data;
        return d;
    endfunction

    function automatic ins_t incoming();
        ins_t e;
        e.pc = in_pc; e.d1 = in_rs1_data; e.d2 = in_rs2_data;
        e.imm = in_imm; e.a1 = in_rs1_addr; e.a2 = in_rs2_addr;
        e.rd = in_rd_addr; e.op = in_alu_ctrl;
        e.si = in_alu_src_imm; e.up = in_use_pc;
        e.rw = in_reg_write; e.mr = in_mem_read;
        e.mw = in_mem_write; e.br = in_branch;
        return e;
    endfunction

    // Reference model: at most one instruction occupies the stage.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            automatic bit had = (q.size() != 0);
            if (flush_i) begin
                q.delete();
            end else begin
                if (had && !out_ready) begin
                    q[0].d1 = fwd(q[0].a1, q[0].d1);
                    q[0].d2 = fwd(q[0].a2, q[0].d2);
                end
                if (had && out_ready) void'(q.pop_front());
                if (in_valid && (!had || out_ready))
                    q.push_back(incoming());
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit ev = (q.size() != 0);
            chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
            chk("in_ready", {31'd0, in_ready},
                {31'd0, !ev || out_ready || flush_i});
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (ev) begin
                automatic ins_t e = q[0];
                automatic logic [31:0] f1 = fwd(e.a1, e.d1);
                automatic logic [31:0] f2 = fwd(e.a2, e.d2);
                chk("pc", pc_o, e.pc);
                chk("rd", {27'd0, rd_addr_o}, {27'd0, e.rd});
                chk("alu_ctrl", {28'd0, alu_ctrl_o}, {28'd0, e.op});
                chk("ctrl", {28'd0, reg_write_o, mem_read_o,
                    mem_write_o, branch_o},
                    {28'd0, e.rw, e.mr, e.mw, e.br});
                chk("operand_a", operand_a_o, e.up ? e.pc : f1);
                chk("operand_b", operand_b_o, e.si ? e.imm : f2);
                chk("store_data", store_data_o, f2);
            end else begin
                chk("gated_ctrl", {28'd0, reg_write_o, mem_read_o,
                    mem_write_o, branch_o}, 32'd0);
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_opa"}, operand_a_o, 32'd0);
        chk({tag, "_opb"}, operand_b_o, 32'd0);
        chk({tag, "_store"}, store_data_o, 32'd0);
        chk({tag, "_pc"}, pc_o, 32'd0);
        chk({tag, "_rd_op"}, {23'd0, rd_addr_o, alu_ctrl_o}, 32'd0);
        chk({tag, "_ctrl"}, {28'd0, reg_write_o, mem_read_o,
            mem_write_o, branch_o}, 32'd0);
    endtask

    task automatic idle();
        in_valid = 0; flush_i = 0; out_ready = 1;
        exm_reg_write = 0; wb_reg_write = 0;
        exm_rd_addr = 0; wb_rd_addr = 0;
        exm_result = 0; wb_data = 0;
    endtask

    task automatic set_ins(logic [31:0] pc, logic [4:0] a1,
                           logic [31:0] d1, logic [4:0] a2,
                           logic [31:0] d2, logic [31:0] imm,
                           logic [3:0] op, logic si, logic mw);
        in_valid = 1; in_pc = pc;
        in_rs1_addr = a1; in_rs1_data = d1;
        in_rs2_addr = a2; in_rs2_data = d2;
        in_imm = imm; in_rd_addr = 5'd9; in_alu_ctrl = op;
        in_alu_src_imm = si; in_use_pc = 0;
        in_reg_write = 1; in_mem_read = 0;
        in_mem_write = mw; in_branch = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic rnd();
        in_valid = ($urandom_range(3) != 0);
        in_pc = $urandom; in_rs1_data = $urandom;
        in_rs2_data = $urandom; in_imm = $urandom;
        in_rs1_addr = 5'($urandom_range(7));
        in_rs2_addr = 5'($urandom_range(7));
        in_rd_addr = 5'($urandom_range(31));
        in_alu_ctrl = 4'($urandom_range(15));
        in_alu_src_imm = 1'($urandom); in_use_pc = 1'($urandom);
        in_reg_write = 1'($urandom); in_mem_read = 1'($urandom);
        in_mem_write = 1'($urandom); in_branch = 1'($urandom);
        flush_i = ($urandom_range(15) == 0);
        out_ready = ($urandom_range(3) != 0);
        exm_reg_write = 1'($urandom);
        exm_rd_addr = 5'($urandom_range(7));
        exm_result = $urandom;
        wb_reg_write = 1'($urandom);
        wb_rd_addr = 5'($urandom_range(7));
        wb_data = $urandom;
    endtask

    initial begin
        idle();
        set_ins(0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0);
        in_valid = 0;
        #1 rst_n = 0;
        #1 check_reset_outputs("reset");
        step(); step();
        rst_n = 1;
        step();

        // Plain load: 5 + imm 7
        set_ins(32'h100, 5'd1, 32'd5, 5'd2, 32'd0, 32'd7, ALU_ADD, 1, 0);
        step();
        idle();
        @(negedge clk);
        chk("plain_opa", operand_a_o, 32'd5);
        chk("plain_opb", operand_b_o, 32'd7);
        step();

        // Double forward on x3, then the same pattern on x0
        set_ins(32'h104, 5'd3, 32'h99, 5'd2, 32'd0, 0, ALU_SUB, 1, 0);
        step();
        idle();
        exm_reg_write = 1; exm_rd_addr = 5'd3; exm_result = 32'h11;
        wb_reg_write = 1; wb_rd_addr = 5'd3; wb_data = 32'h22;
        @(negedge clk);
        chk("dfwd_opa", operand_a_o, 32'h11);
        step();
        set_ins(32'h108, 5'd0, 32'h99, 5'd2, 32'd0, 0, ALU_OR, 1, 0);
        exm_reg_write = 0; wb_reg_write = 0;
        step();
        exm_reg_write = 1; exm_rd_addr = 5'd0; exm_result = 32'h11;
        wb_reg_write = 1; wb_rd_addr = 5'd0; wb_data = 32'h22;
        in_valid = 0;
        @(negedge clk);
        chk("x0_opa", operand_a_o, 32'h99);
        step();
        idle();

        // Stall while x4 retires through MEM/WB in the first cycle only
        set_ins(32'h10c, 5'd1, 32'd1, 5'd4, 32'h1, 0, ALU_AND, 0, 1);
        step();
        set_ins(32'h110, 5'd1, 32'd2, 5'd2, 32'd3, 0, ALU_XOR, 0, 0);
        out_ready = 0;
        wb_reg_write = 1; wb_rd_addr = 5'd4; wb_data = 32'hAB;
        @(negedge clk);
        chk("stall1_opb", operand_b_o, 32'hAB);
        step();
        wb_reg_write = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_opb", operand_b_o, 32'hAB);
            chk("stall_store", store_data_o, 32'hAB);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1;
        step();
        idle();
        step();

        // Flush kills both the held store and the incoming instruction
        set_ins(32'h200, 5'd1, 32'd1, 5'd2, 32'd2, 0, ALU_ADD, 0, 1);
        step();
        idle(); out_ready = 0;
        step();
        set_ins(32'h204, 5'd1, 32'd1, 5'd2, 32'd2, 0, ALU_SLL, 0, 1);
        flush_i = 1; out_ready = 0;
        step();
        idle();
        @(negedge clk);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_mw", {31'd0, mem_write_o}, 32'd0);
        step(); step();

        // Throughput: 8 back-to-back instructions, no bubbles
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            set_ins(32'h300 + 32'(4 * i), 5'd1, 32'(i), 5'd2, 32'(i),
                    32'(i), ALU_SRL, 1, 0);
            step();
        end
        idle();
        step(); step();
        chk("throughput_run", 32'(max_run), 32'd8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rnd();
            step();
        end

        // Asynchronous reset while stalled discards the held instruction
        idle();
        set_ins(32'h400, 5'd1, 32'h5, 5'd2, 32'h6, 32'h7, ALU_SUB, 0, 1);
        step();
        in_valid = 0; out_ready = 0;
        step();
        #2 rst_n = 0;
        #1 check_reset_outputs("midreset");
        @(negedge clk); #1;
        idle();
        rst_n = 1;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
